// File: rtl/xmodem_pkg.sv
// Shared constants and state encoding for the XMODEM receiver slice.
package xmodem_pkg;

  localparam int XM_BLOCK_BYTES = 128;
  localparam int XM_IDX_W       = 7;

  localparam logic [7:0] XM_SOH = 8'h01;
  localparam logic [7:0] XM_EOT = 8'h04;
  localparam logic [7:0] XM_ACK = 8'h06;
  localparam logic [7:0] XM_NAK = 8'h15;
  localparam logic [7:0] XM_CAN = 8'h18;

  typedef enum logic [3:0] {
    S_START = 4'd0,
    S_HDR   = 4'd1,
    S_BLK   = 4'd2,
    S_BLKN  = 4'd3,
    S_DATA  = 4'd4,
    S_CSUM  = 4'd5,
    S_DRAIN = 4'd6,
    S_REPLY = 4'd7,
    S_DONE  = 4'd8,
    S_ABORT = 4'd9
  } xm_state_t;

endpackage

// File: rtl/xmodem_if.sv
// UART byte links plus the payload stream towards scene_loader.
// tx handshake: tx_byte moves when tx_valid && tx_ready at a clock edge; once
// raised, tx_valid and tx_byte hold steady until that edge. rx_valid is a
// one-cycle strobe with no back-pressure.
interface xmodem_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] xmodem_data_byte;
  logic       xmodem_saw_valid_msg_byte;
  logic       xmodem_saw_valid_block;
  logic [7:0] sl_block_num;
  logic       xmodem_done;
  logic       xmodem_error;

  modport master (
    input  rx_byte, rx_valid, tx_ready,
    output tx_byte, tx_valid, xmodem_data_byte, xmodem_saw_valid_msg_byte,
           xmodem_saw_valid_block, sl_block_num, xmodem_done, xmodem_error
  );

  modport slave (
    output rx_byte, rx_valid, tx_ready,
    input  tx_byte, tx_valid, xmodem_data_byte, xmodem_saw_valid_msg_byte,
           xmodem_saw_valid_block, sl_block_num, xmodem_done, xmodem_error
  );
endinterface

// File: rtl/xmodem_block_buf.sv
// 128x8 payload buffer: one write port, one registered read port.
module xmodem_block_buf
  import xmodem_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [XM_IDX_W-1:0] wr_addr,
  input  logic [7:0]          wr_data,
  input  logic [XM_IDX_W-1:0] rd_addr,
  output logic [7:0]          rd_data
);

  logic [7:0] mem [XM_BLOCK_BYTES];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/xmodem_receiver.sv
// XMODEM (128-byte, 8-bit checksum) receiver: parses packets from the UART,
// streams verified new blocks to scene_loader and answers ACK/NAK/CAN.
module xmodem_receiver
  import xmodem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int MAX_RETRIES    = 10
) (
  input  logic      clk,
  input  logic      rst,
  xmodem_if.master  xm,
  output xm_state_t state_dbg
);

  xm_state_t           state, reply_next;
  logic [31:0]         tmo_cnt;
  logic [7:0]          blk, csum, expected, retries;
  logic                bad;
  logic [XM_IDX_W-1:0] idx, drain_idx;
  logic                drain_tail;
  logic                msg_q, block_q, tx_valid_q, done_q, error_q;
  logic [7:0]          tx_byte_q, sl_blk_q;

  logic                counting, rx_take, tmo_hit, nak_req, give_up, blk_ok;
  logic [XM_IDX_W-1:0] rd_addr;
  logic [7:0]          rd_data;

  assign counting = (state inside {S_START, S_HDR, S_BLK, S_BLKN, S_DATA, S_CSUM});
  assign rx_take  = xm.rx_valid && counting;
  // A byte arriving on the terminal count wins over the timeout.
  assign tmo_hit  = counting && !xm.rx_valid && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign give_up  = (retries == 8'(MAX_RETRIES - 1));
  assign blk_ok   = (blk == expected) || (blk == 8'(expected - 8'd1));

  always_comb begin
    nak_req = 1'b0;
    if (state inside {S_HDR, S_BLK, S_BLKN, S_DATA, S_CSUM} && tmo_hit) nak_req = 1'b1;
    if (state == S_HDR && rx_take && xm.rx_byte != XM_SOH && xm.rx_byte != XM_EOT)
      nak_req = 1'b1;
    if (state == S_CSUM && rx_take && (bad || csum != xm.rx_byte || !blk_ok))
      nak_req = 1'b1;
  end

  // Outside DRAIN the read port sits on address 0, so byte 0 is already on
  // rd_data when the checksum byte arrives.
  assign rd_addr = (state == S_DRAIN && !drain_tail) ? XM_IDX_W'(drain_idx + 1'b1) : '0;

  xmodem_block_buf u_buf (
    .clk     (clk),
    .we      (state == S_DATA && rx_take),
    .wr_addr (idx),
    .wr_data (xm.rx_byte),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_START;
      reply_next <= S_START;
      tmo_cnt    <= '0;
      blk        <= '0;
      csum       <= '0;
      expected   <= 8'd1;
      retries    <= '0;
      bad        <= 1'b0;
      idx        <= '0;
      drain_idx  <= '0;
      drain_tail <= 1'b0;
      msg_q      <= 1'b0;
      block_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= '0;
      sl_blk_q   <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      msg_q   <= 1'b0;
      block_q <= 1'b0;
      if (rx_take || !counting) tmo_cnt <= '0;
      else                      tmo_cnt <= tmo_cnt + 32'd1;

      case (state)
        S_START: begin
          if (tmo_hit) begin
            tx_valid_q <= 1'b1;
            tx_byte_q  <= XM_NAK;
            reply_next <= S_START;
            state      <= S_REPLY;
          end else if (rx_take && xm.rx_byte == XM_SOH) begin
            state <= S_BLK;
          end
        end
        S_HDR: begin
          if (rx_take && xm.rx_byte == XM_SOH) begin
            state <= S_BLK;
          end else if (rx_take && xm.rx_byte == XM_EOT) begin
            tx_valid_q <= 1'b1;
            tx_byte_q  <= XM_ACK;
            reply_next <= S_DONE;
            state      <= S_REPLY;
          end
        end
        S_BLK: begin
          if (rx_take) begin
            blk   <= xm.rx_byte;
            idx   <= '0;
            csum  <= '0;
            bad   <= 1'b0;
            state <= S_BLKN;
          end
        end
        S_BLKN: begin
          if (rx_take) begin
            bad   <= (xm.rx_byte != ~blk);
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (rx_take) begin
            csum <= csum + xm.rx_byte;
            idx  <= XM_IDX_W'(idx + 1'b1);
            if (idx == XM_IDX_W'(XM_BLOCK_BYTES - 1)) state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (rx_take && !nak_req) begin
            if (blk == expected) begin
              msg_q      <= 1'b1;
              drain_idx  <= '0;
              drain_tail <= 1'b0;
              sl_blk_q   <= blk;
              state      <= S_DRAIN;
            end else begin
              // Duplicate of the last accepted block: acknowledge, don't stream.
              retries    <= '0;
              tx_valid_q <= 1'b1;
              tx_byte_q  <= XM_ACK;
              reply_next <= S_HDR;
              state      <= S_REPLY;
            end
          end
        end
        S_DRAIN: begin
          if (!drain_tail) begin
            drain_idx <= XM_IDX_W'(drain_idx + 1'b1);
            if (drain_idx == XM_IDX_W'(XM_BLOCK_BYTES - 1)) begin
              drain_tail <= 1'b1;
              block_q    <= 1'b1;
            end else begin
              msg_q <= 1'b1;
            end
          end else begin
            expected   <= expected + 8'd1;
            retries    <= '0;
            tx_valid_q <= 1'b1;
            tx_byte_q  <= XM_ACK;
            reply_next <= S_HDR;
            state      <= S_REPLY;
          end
        end
        S_REPLY: begin
          if (xm.tx_ready) begin
            tx_valid_q <= 1'b0;
            state      <= reply_next;
            if (reply_next == S_DONE)  done_q  <= 1'b1;
            if (reply_next == S_ABORT) error_q <= 1'b1;
          end
        end
        default: ;
      endcase

      // Any NAK-worthy event overrides the per-state transition above.
      if (nak_req) begin
        tx_valid_q <= 1'b1;
        state      <= S_REPLY;
        if (give_up) begin
          tx_byte_q  <= XM_CAN;
          reply_next <= S_ABORT;
        end else begin
          tx_byte_q  <= XM_NAK;
          reply_next <= S_HDR;
          retries    <= retries + 8'd1;
        end
      end
    end
  end

  assign xm.tx_byte                   = tx_byte_q;
  assign xm.tx_valid                  = tx_valid_q;
  assign xm.xmodem_data_byte          = msg_q ? rd_data : 8'h00;
  assign xm.xmodem_saw_valid_msg_byte = msg_q;
  assign xm.xmodem_saw_valid_block    = block_q;
  assign xm.sl_block_num              = sl_blk_q;
  assign xm.xmodem_done               = done_q;
  assign xm.xmodem_error              = error_q;
  assign state_dbg                    = state;

endmodule

// File: tb/tb_xmodem_receiver.sv
// Directed bench for xmodem_receiver: start NAKs, good/bad/duplicate blocks,
// block-number wrap, timeout, retry abort and EOT completion.
module tb_xmodem_receiver;
  import xmodem_pkg::*;

  localparam int TMO  = 1000;
  localparam int MAXR = 10;

  // clock / reset
  logic      clk = 1'b0;
  logic      rst;
  xm_state_t state_dbg;
  xmodem_if  xif();

  xmodem_receiver #(.TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MAXR)) dut (
    .clk       (clk),
    .rst       (rst),
    .xm        (xif),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // scoreboard state
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  int          block_pulses = 0;
  int          cyc = 0;
  int          last_msg_cyc = 0;
  int          txv_rise_cyc = 0;
  int          last_wait = 0;
  logic        prev_msg = 1'b0;
  logic        prev_txv = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [7:0]  prev_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return 32'({xif.tx_valid, xif.tx_byte, xif.xmodem_data_byte, xif.xmodem_saw_valid_msg_byte,
                xif.xmodem_saw_valid_block, xif.sl_block_num, xif.xmodem_done, xif.xmodem_error});
  endfunction

  // driver tasks (called at a negedge)
  task automatic send_byte(input logic [7:0] b);
    xif.rx_byte  = b;
    xif.rx_valid = 1'b1;
    @(negedge clk);
    xif.rx_valid = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] blk, input logic [7:0] data [128],
                             input logic [7:0] csum_xor, input logic [7:0] blkn_xor);
    logic [7:0] cs;
    cs = 8'h00;
    send_byte(XM_SOH);
    send_byte(blk);
    send_byte(~blk ^ blkn_xor);
    for (int i = 0; i < 128; i++) begin
      send_byte(data[i]);
      cs = cs + data[i];
    end
    send_byte(cs ^ csum_xor);
  endtask

  task automatic push_block(input logic [7:0] blk, input logic [7:0] data [128]);
    for (int i = 0; i < 128; i++) exp_q.push_back({blk, data[i]});
  endtask

  task automatic wait_reply(input string tag, input logic [7:0] code, input int budget);
    int n;
    n = 0;
    while (!(xif.tx_valid && xif.tx_ready) && n < budget) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    checks++;
    assert (n < budget) else begin
      errors++;
      $error("FAIL %s_wait: no reply within %0d cycles", tag, budget);
    end
    if (n < budget) begin
      check(tag, 32'(xif.tx_byte), 32'(code));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    xif.rx_valid = 1'b0;
    xif.rx_byte  = 8'h00;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", out_vec(), 32'h0);
    check("rst_state", 32'(state_dbg), 32'(S_START));
    rst = 1'b1;
    @(negedge clk);
  endtask

  // tx_ready changes just after posedge so it is stable at every sample point
  initial begin
    xif.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 xif.tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // output monitor
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (xif.xmodem_saw_valid_msg_byte) begin
        check("msg_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          check("msg_byte", 32'({xif.sl_block_num, xif.xmodem_data_byte}), 32'(exp_q.pop_front()));
        last_msg_cyc = cyc;
      end
      if (xif.xmodem_saw_valid_block) begin
        block_pulses++;
        check("block_after_last", 32'({prev_msg, exp_q.size() == 0}), 32'd3);
      end
      if (xif.tx_valid && !prev_txv) txv_rise_cyc = cyc;
      if (prev_txv && !prev_rdy)
        check("tx_hold", 32'({xif.tx_valid, xif.tx_byte}), 32'({1'b1, prev_byte}));
      prev_msg  = xif.xmodem_saw_valid_msg_byte;
      prev_txv  = xif.tx_valid;
      prev_rdy  = xif.tx_ready;
      prev_byte = xif.tx_byte;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] data [128];
    logic [7:0] blk;
    rst = 1'b0;
    xif.rx_valid = 1'b0;
    xif.rx_byte  = 8'h00;
    do_reset();

    // start-up NAKs, nothing else
    wait_reply("start_nak1", XM_NAK, TMO + 100);
    check("start_nak1_period", 32'(last_wait >= TMO - 20 && last_wait <= TMO + 20), 32'd1);
    wait_reply("start_nak2", XM_NAK, TMO + 100);
    check("start_nak2_period", 32'(last_wait >= TMO - 20 && last_wait <= TMO + 20), 32'd1);
    check("start_no_flags", 32'({xif.xmodem_done, xif.xmodem_error}), 32'd0);
    check("start_no_blocks", 32'(block_pulses), 32'd0);

    // block 1 with bad checksum, then correct
    for (int i = 0; i < 128; i++) data[i] = 8'(i);
    send_packet(8'd1, data, 8'h01, 8'h00);
    wait_reply("bad_csum_nak", XM_NAK, 400);
    check("bad_csum_no_stream", 32'(block_pulses), 32'd0);
    push_block(8'd1, data);
    send_packet(8'd1, data, 8'h00, 8'h00);
    check("first_msg_latency", 32'({xif.xmodem_saw_valid_msg_byte, xif.xmodem_data_byte}), 32'h100);
    wait_reply("blk1_ack", XM_ACK, 400);
    check("blk1_ack_latency", 32'(txv_rise_cyc - last_msg_cyc), 32'd2);
    check("blk1_drained", 32'(exp_q.size()), 32'd0);

    // duplicate block 1
    send_packet(8'd1, data, 8'h00, 8'h00);
    wait_reply("dup_ack", XM_ACK, 400);
    check("dup_no_stream", 32'(block_pulses), 32'd1);

    // blocks 2..257 with block-number wrap
    for (int b = 2; b <= 257; b++) begin
      blk = 8'(b);
      for (int i = 0; i < 128; i++) data[i] = 8'($urandom_range(0, 255));
      push_block(blk, data);
      send_packet(blk, data, 8'h00, 8'h00);
      wait_reply("blk_ack", XM_ACK, 400);
      check("blk_ack_latency", 32'(txv_rise_cyc - last_msg_cyc), 32'd2);
      check("blk_drained", 32'(exp_q.size()), 32'd0);
    end
    check("block_pulse_total", 32'(block_pulses), 32'd257);
    check("final_block_num", 32'(xif.sl_block_num), 32'd1);

    // partial packet then silence
    do_reset();
    send_byte(XM_SOH);
    for (int i = 0; i < 50; i++) send_byte(8'($urandom_range(0, 255)));
    wait_reply("partial_tmo_nak", XM_NAK, TMO + 100);
    check("partial_tmo_period", 32'(last_wait >= TMO - 5 && last_wait <= TMO + 20), 32'd1);

    // ten bad packets -> CAN
    do_reset();
    for (int i = 0; i < 128; i++) data[i] = 8'($urandom_range(0, 255));
    for (int p = 1; p <= 10; p++) begin
      if (p == 5) send_packet(8'd1, data, 8'h00, 8'h01);
      else        send_packet(8'd1, data, 8'h5A, 8'h00);
      if (p < 10) begin
        wait_reply("retry_nak", XM_NAK, 400);
        check("retry_no_error", 32'(xif.xmodem_error), 32'd0);
      end else begin
        wait_reply("retry_can", XM_CAN, 400);
      end
    end
    repeat (3) @(negedge clk);
    check("abort_flags", 32'({xif.xmodem_error, xif.xmodem_done}), 32'd2);
    check("abort_state", 32'(state_dbg), 32'(S_ABORT));
    check("abort_no_blocks", 32'(block_pulses), 32'd257);

    // good block then EOT
    do_reset();
    for (int i = 0; i < 128; i++) data[i] = 8'(255 - i);
    push_block(8'd1, data);
    send_packet(8'd1, data, 8'h00, 8'h00);
    wait_reply("eot_blk1_ack", XM_ACK, 400);
    send_byte(XM_EOT);
    wait_reply("eot_ack", XM_ACK, 50);
    repeat (5) @(negedge clk);
    check("done_flags", 32'({xif.xmodem_done, xif.xmodem_error}), 32'd2);
    check("done_state", 32'(state_dbg), 32'(S_DONE));
    check("done_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
